// File: rtl/jar_digit_pacer.sv
// Paces pi-digit display: requests digits upstream, shows each on a 7-segment output, then blanks.
// state  | meaning
// IDLE   | waiting for enable; display blank
// REQ    | one-cycle advance strobe to the upstream generator
// WAIT   | fixed upstream latency before hex_in is valid
// SHOW   | digit displayed; hold timer runs while enabled
// GAP    | blank interval separating consecutive digits
module jar_digit_pacer #(
    parameter int unsigned HOLD_BASE = 1000,
    parameter int unsigned GAP_TICKS = 200,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] div_sel,
    input  logic [3:0] hex_in,
    output logic       advance,
    output logic [7:0] segments,
    output logic [8:0] digit_count,
    output logic       busy
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SHOW, S_GAP} state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAT_LD  = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_BASE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       digit_q, digit_d;
    logic [8:0]       count_q, count_d;
    logic             advance_q, advance_d;
    logic             busy_q, busy_d;
    logic [7:0]       seg_q, seg_d;
    logic             cnt_last;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'h0: font = 7'h3F;
            4'h1: font = 7'h06;
            4'h2: font = 7'h5B;
            4'h3: font = 7'h4F;
            4'h4: font = 7'h66;
            4'h5: font = 7'h6D;
            4'h6: font = 7'h7D;
            4'h7: font = 7'h07;
            4'h8: font = 7'h7F;
            4'h9: font = 7'h6F;
            4'hA: font = 7'h77;
            4'hB: font = 7'h7C;
            4'hC: font = 7'h39;
            4'hD: font = 7'h5E;
            4'hE: font = 7'h79;
            default: font = 7'h71;
        endcase
    endfunction

    // The edge that takes the counter from 1 to 0 is the phase-ending edge.
    assign cnt_last = (cnt_q <= ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    cnt_d   = LAT_LD;
                    state_d = S_WAIT;
                end
            end
            S_REQ: begin
                cnt_d   = LAT_LD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_last) begin
                    digit_d = hex_in;
                    cnt_d   = HOLD_LD << div_sel;
                    state_d = S_SHOW;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_SHOW: begin
                if (enable) begin
                    if (cnt_last) begin
                        count_d = count_q + 9'd1;
                        cnt_d   = GAP_LD;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
            S_GAP: begin
                if (enable) begin
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        advance_d = (state_d == S_REQ);
        busy_d    = (state_d != S_IDLE);
        seg_d     = (state_d == S_SHOW) ? {(count_d == 9'd0), font(digit_d)} : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            digit_q   <= 4'h0;
            count_q   <= 9'd0;
            advance_q <= 1'b0;
            busy_q    <= 1'b0;
            seg_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            count_q   <= count_d;
            advance_q <= advance_d;
            busy_q    <= busy_d;
            seg_q     <= seg_d;
        end
    end

    assign advance     = advance_q;
    assign segments    = seg_q;
    assign digit_count = count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_jar_digit_pacer.sv
// Bench for jar_digit_pacer: time-budget reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_jar_digit_pacer;

    localparam int HB  = 4;
    localparam int GT  = 2;
    localparam int LAT = 2;

    localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] div_sel = 2'd0;
    logic [3:0] hex_in;
    logic       advance;
    logic [7:0] segments;
    logic [8:0] digit_count;
    logic       busy;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    jar_digit_pacer #(.HOLD_BASE(HB), .GAP_TICKS(GT), .LATENCY(LAT), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .div_sel(div_sel), .hex_in(hex_in),
        .advance(advance), .segments(segments), .digit_count(digit_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Upstream generator: index steps on the advance edge, digit appears one cycle later.
    logic [3:0] tbl [1024];
    logic [9:0] up_idx = 10'd0;
    always @(posedge clk) begin
        if (advance) up_idx <= up_idx + 10'd1;
        hex_in <= tbl[up_idx];
    end

    // Reference: current phase plus the number of enabled cycles still owed to it.
    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_SHOW = 3, P_GAP = 4;
    int         m_phase = P_IDLE;
    int         m_left = 0;
    int         m_count = 0;
    logic [3:0] m_digit = 4'h0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = P_IDLE; m_left = 0; m_count = 0; m_digit = 4'h0;
        end else begin
            case (m_phase)
                P_IDLE: if (enable) begin m_phase = P_WAIT; m_left = LAT; end
                P_REQ:  begin m_phase = P_WAIT; m_left = LAT; end
                P_WAIT: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_digit = hex_in; m_phase = P_SHOW; m_left = HB * (1 << div_sel);
                    end
                end
                P_SHOW: if (enable) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_count = (m_count + 1) % 512; m_phase = P_GAP; m_left = GT;
                    end
                end
                default: if (enable) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = P_REQ;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        logic       e_adv, e_busy;
        logic [7:0] e_seg;
        logic [8:0] e_cnt;
        if (chk_en) begin
            e_adv  = (m_phase == P_REQ);
            e_busy = (m_phase != P_IDLE);
            e_seg  = (m_phase == P_SHOW) ? {(m_count == 0), FONT[m_digit]} : 8'h00;
            e_cnt  = 9'(m_count);
            tests++;
            if ({advance, busy, segments, digit_count} !== {e_adv, e_busy, e_seg, e_cnt}) begin
                fails++;
                $display("FAIL model_cmp t=%0t got adv=%b busy=%b seg=%h cnt=%0d expected adv=%b busy=%b seg=%h cnt=%0d",
                         $time, advance, busy, segments, digit_count, e_adv, e_busy, e_seg, e_cnt);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic show_len(input int change_at, output int len);
        int k;
        k = 0;
        len = 0;
        while (segments == 8'h00 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (segments == 8'h00) begin
            tests++; fails++;
            $display("FAIL show_start timeout t=%0t got blank expected a digit", $time);
            return;
        end
        len = 1;
        for (int i = 0; i < 200; i++) begin
            if (len == change_at) div_sel = 2'd0;
            @(negedge clk);
            if (segments == 8'h00) break;
            len++;
        end
    endtask

    initial begin
        int         n, k, ph, len;
        logic [7:0] held, e_seg;
        logic [3:0] snap;

        tbl[0] = 4'd3; tbl[1] = 4'd1; tbl[2] = 4'd4;
        for (int i = 3; i < 1024; i++) tbl[i] = 4'($urandom_range(0, 15));

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_adv", 32'(advance), 32'h0);
        check("rst_seg", 32'(segments), 32'h0);
        check("rst_cnt", 32'(digit_count), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);

        // First three digits 3,1,4 at div_sel=0: period 9, five blank cycles between digits.
        enable = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            @(negedge clk);
            e_seg = (t >= 3 && t <= 6) ? 8'hCF : (t >= 12 && t <= 15) ? 8'h06 :
                    (t >= 21 && t <= 24) ? 8'h66 : 8'h00;
            check("s2_seg", 32'(segments), 32'(e_seg));
            check("s2_adv", 32'(advance), (t == 9 || t == 18) ? 32'h1 : 32'h0);
            if (t == 7)  check("s1_cnt", 32'(digit_count), 32'd1);
            if (t == 16) check("s2_cnt", 32'(digit_count), 32'd2);
        end

        // div_sel=3 for one digit, cleared mid-SHOW.
        div_sel = 2'd3;
        @(negedge clk);
        show_len(10, len);
        check("s3_len32", 32'(len), 32'd32);
        show_len(0, len);
        check("s3_len4", 32'(len), 32'd4);

        // Pause in SHOW, then in GAP.
        k = 0;
        while (segments == 8'h00 && k < 100) begin @(negedge clk); k++; end
        held = segments;
        check("s4_started", 32'(held != 8'h00), 32'h1);
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("s4_hold_seg", 32'(segments), 32'(held));
            check("s4_hold_adv", 32'(advance), 32'h0);
        end
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (segments == 8'h00) break;
            n++;
        end
        check("s4_show_rest", 32'(n), 32'd2);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("s4_gap_seg", 32'(segments), 32'h0);
            check("s4_gap_adv", 32'(advance), 32'h0);
        end
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (advance) break;
        end
        check("s4_gap_rest", 32'(n), 32'd2);

        // Random enable/div_sel until digit_count wraps and dp returns.
        ph = 0;
        for (int c = 0; c < 30000 && ph != 3; c++) begin
            @(negedge clk);
            if (ph == 0 && digit_count == 9'd511) ph = 1;
            else if (ph == 1 && digit_count != 9'd511) begin
                check("s5_wrap", 32'(digit_count), 32'd0);
                ph = 2;
            end else if (ph == 2 && segments != 8'h00) begin
                check("s5_dp", 32'(segments[7]), 32'h1);
                ph = 3;
            end
            enable  = ($urandom_range(0, 7) != 0);
            div_sel = 2'($urandom_range(0, 1));
        end
        if (ph != 3) begin
            tests++; fails++;
            $display("FAIL s5_timeout got phase %0d expected 3", ph);
        end

        // Asynchronous reset during REQ.
        enable = 1'b1;
        div_sel = 2'd0;
        k = 0;
        while (!advance && k < 200) begin @(negedge clk); k++; end
        check("s6_in_req", 32'(advance), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("s6_adv", 32'(advance), 32'h0);
        check("s6_seg", 32'(segments), 32'h0);
        check("s6_busy", 32'(busy), 32'h0);
        check("s6_cnt", 32'(digit_count), 32'h0);
        snap = tbl[up_idx];
        @(negedge clk);
        reset = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            check("s6_noadv", 32'(advance), 32'h0);
            check("s6_busy_run", 32'(busy), 32'h1);
            check("s6_seg_run", 32'(segments), (t == 3) ? 32'({1'b1, FONT[snap]}) : 32'h0);
        end
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
